// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - symbol codes, glyph patterns and the symbol-to-glyph decode function
package seg_pkg;

   localparam int SYM_W = 5;

   localparam logic [SYM_W-1:0] SYM_BLANK = 5'd0;
   localparam logic [SYM_W-1:0] SYM_0     = 5'd1;
   localparam logic [SYM_W-1:0] SYM_1     = 5'd2;
   localparam logic [SYM_W-1:0] SYM_2     = 5'd3;
   localparam logic [SYM_W-1:0] SYM_3     = 5'd4;
   localparam logic [SYM_W-1:0] SYM_4     = 5'd5;
   localparam logic [SYM_W-1:0] SYM_5     = 5'd6;
   localparam logic [SYM_W-1:0] SYM_6     = 5'd7;
   localparam logic [SYM_W-1:0] SYM_7     = 5'd8;
   localparam logic [SYM_W-1:0] SYM_8     = 5'd9;
   localparam logic [SYM_W-1:0] SYM_9     = 5'd10;
   localparam logic [SYM_W-1:0] SYM_A     = 5'd11;
   localparam logic [SYM_W-1:0] SYM_B     = 5'd12;
   localparam logic [SYM_W-1:0] SYM_C     = 5'd13;
   localparam logic [SYM_W-1:0] SYM_D     = 5'd14;
   localparam logic [SYM_W-1:0] SYM_E     = 5'd15;
   localparam logic [SYM_W-1:0] SYM_F     = 5'd16;
   localparam logic [SYM_W-1:0] SYM_DASH  = 5'd17;
   localparam logic [SYM_W-1:0] SYM_L     = 5'd18;
   localparam logic [SYM_W-1:0] SYM_LO_D  = 5'd19;
   localparam logic [SYM_W-1:0] SYM_P     = 5'd20;
   localparam logic [SYM_W-1:0] SYM_LO_N  = 5'd21;

   // Segment order {a,b,c,d,e,f,g}, 1 = lit
   localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
   localparam logic [6:0] GLYPH_0     = 7'b1111110;
   localparam logic [6:0] GLYPH_1     = 7'b0110000;
   localparam logic [6:0] GLYPH_2     = 7'b1101101;
   localparam logic [6:0] GLYPH_3     = 7'b1111001;
   localparam logic [6:0] GLYPH_4     = 7'b0110011;
   localparam logic [6:0] GLYPH_5     = 7'b1011011;
   localparam logic [6:0] GLYPH_6     = 7'b1011111;
   localparam logic [6:0] GLYPH_7     = 7'b1110000;
   localparam logic [6:0] GLYPH_8     = 7'b1111111;
   localparam logic [6:0] GLYPH_9     = 7'b1111011;
   localparam logic [6:0] GLYPH_A     = 7'b1110111;
   localparam logic [6:0] GLYPH_B     = 7'b0011111;
   localparam logic [6:0] GLYPH_C     = 7'b1001110;
   localparam logic [6:0] GLYPH_D     = 7'b0111101;
   localparam logic [6:0] GLYPH_E     = 7'b1001111;
   localparam logic [6:0] GLYPH_F     = 7'b1000111;
   localparam logic [6:0] GLYPH_DASH  = 7'b0000001;
   localparam logic [6:0] GLYPH_L     = 7'b0001110;
   localparam logic [6:0] GLYPH_P     = 7'b1100111;
   localparam logic [6:0] GLYPH_LO_N  = 7'b0010101;

   function automatic logic [6:0] sym_to_glyph(input logic [SYM_W-1:0] code);
      case (code)
         SYM_0:    return GLYPH_0;
         SYM_1:    return GLYPH_1;
         SYM_2:    return GLYPH_2;
         SYM_3:    return GLYPH_3;
         SYM_4:    return GLYPH_4;
         SYM_5:    return GLYPH_5;
         SYM_6:    return GLYPH_6;
         SYM_7:    return GLYPH_7;
         SYM_8:    return GLYPH_8;
         SYM_9:    return GLYPH_9;
         SYM_A:    return GLYPH_A;
         SYM_B:    return GLYPH_B;
         SYM_C:    return GLYPH_C;
         SYM_D:    return GLYPH_D;
         SYM_E:    return GLYPH_E;
         SYM_F:    return GLYPH_F;
         SYM_DASH: return GLYPH_DASH;
         SYM_L:    return GLYPH_L;
         SYM_LO_D: return GLYPH_D;
         SYM_P:    return GLYPH_P;
         SYM_LO_N: return GLYPH_LO_N;
         // Blank and the unused codes 22..31 all stay dark
         default:  return GLYPH_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational symbol code to active-high glyph decoder
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic [6:0]       glyph
);

   assign glyph = sym_to_glyph(sym);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scanner with blink, dp and frame-synchronous updates
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int BLINK_DIV      = 12500000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        load,
   input  logic [SYM_W*NUM_DIGITS-1:0] sym_in,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic [NUM_DIGITS-1:0]       blink_mask,
   output logic [6:0]                  seg_out,
   output logic                        dp_out,
   output logic [NUM_DIGITS-1:0]       an_out,
   output logic                        frame_done
);

   localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SLOT_W  = $clog2(REFRESH_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);

   localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [DIG_W-1:0]      DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
   localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

   logic [SLOT_W-1:0]           slot_cnt_q, slot_cnt_d;
   logic [DIG_W-1:0]            digit_q, digit_d;
   logic [BLINK_W-1:0]          blink_cnt_q, blink_cnt_d;
   logic                        blink_phase_q, blink_phase_d;
   logic [SYM_W*NUM_DIGITS-1:0] shadow_sym_q, shadow_sym_d, pend_sym_q, pend_sym_d;
   logic [NUM_DIGITS-1:0]       shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]       shadow_blink_q, shadow_blink_d, pend_blink_q, pend_blink_d;
   logic                        pend_v_q, pend_v_d;
   logic [6:0]                  seg_q, seg_d;
   logic                        dp_q, dp_d;
   logic [NUM_DIGITS-1:0]       an_q, an_d;
   logic                        frame_done_q, frame_done_d;

   logic                        boundary;
   logic [SYM_W-1:0]            cur_sym;
   logic                        cur_dp, cur_blink, lit_ok;
   logic [6:0]                  cur_glyph;
   logic [NUM_DIGITS-1:0]       an_on;

   always_comb begin
      boundary      = enable && (digit_q == DIG_LAST) && (slot_cnt_q == SLOT_LAST);
      slot_cnt_d    = slot_cnt_q;
      digit_d       = digit_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!enable) begin
         slot_cnt_d    = '0;
         digit_d       = '0;
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else begin
         if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            digit_d    = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
         end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
         end
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   // A load that cannot tear a frame (idle, or exactly on the boundary) bypasses pending
   always_comb begin
      shadow_sym_d   = shadow_sym_q;
      shadow_dp_d    = shadow_dp_q;
      shadow_blink_d = shadow_blink_q;
      pend_sym_d     = pend_sym_q;
      pend_dp_d      = pend_dp_q;
      pend_blink_d   = pend_blink_q;
      pend_v_d       = pend_v_q;
      if (load && (!enable || boundary)) begin
         shadow_sym_d   = sym_in;
         shadow_dp_d    = dp_in;
         shadow_blink_d = blink_mask;
         pend_v_d       = 1'b0;
      end else if (load) begin
         pend_sym_d   = sym_in;
         pend_dp_d    = dp_in;
         pend_blink_d = blink_mask;
         pend_v_d     = 1'b1;
      end else if (boundary && pend_v_q) begin
         shadow_sym_d   = pend_sym_q;
         shadow_dp_d    = pend_dp_q;
         shadow_blink_d = pend_blink_q;
         pend_v_d       = 1'b0;
      end
   end

   always_comb begin
      cur_sym   = '0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      an_on     = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_q == DIG_W'(k)) begin
            cur_sym   = shadow_sym_q[k*SYM_W +: SYM_W];
            cur_dp    = shadow_dp_q[k];
            cur_blink = shadow_blink_q[k];
            an_on[k]  = (slot_cnt_q != '0);
         end
      end
   end

   seg_glyph_decode u_decode (
      .sym   (cur_sym),
      .glyph (cur_glyph)
   );

   always_comb begin
      lit_ok       = enable && !(cur_blink && !blink_phase_q);
      seg_d        = (lit_ok ? cur_glyph : 7'h00) ^ SEG_OFF;
      dp_d         = (lit_ok && cur_dp) ^ DP_OFF;
      an_d         = (enable ? an_on : '0) ^ AN_OFF;
      frame_done_d = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q     <= '0;
         digit_q        <= '0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b1;
         shadow_sym_q   <= '0;
         shadow_dp_q    <= '0;
         shadow_blink_q <= '0;
         pend_sym_q     <= '0;
         pend_dp_q      <= '0;
         pend_blink_q   <= '0;
         pend_v_q       <= 1'b0;
         seg_q          <= SEG_OFF;
         dp_q           <= DP_OFF;
         an_q           <= AN_OFF;
         frame_done_q   <= 1'b0;
      end else begin
         slot_cnt_q     <= slot_cnt_d;
         digit_q        <= digit_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
         shadow_sym_q   <= shadow_sym_d;
         shadow_dp_q    <= shadow_dp_d;
         shadow_blink_q <= shadow_blink_d;
         pend_sym_q     <= pend_sym_d;
         pend_dp_q      <= pend_dp_d;
         pend_blink_q   <= pend_blink_d;
         pend_v_q       <= pend_v_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         an_q           <= an_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;
   assign frame_done = frame_done_q;

endmodule
